// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder
// Purpose  : WIDTH-bit adder that runs one 4-bit carry-lookahead slice per
//            cycle (LSB nibble first), with valid/ready on both sides.
//            Optional subtract port enabled by defining NSA_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_ci,
`ifdef NSA_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_co,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);
    localparam logic [IW-1:0] C_LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               cy_q, cy_d;

    logic               w_accept;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_ci_in;
    logic [3:0]         w_na, w_nb, w_g, w_p, w_sum;
    logic [4:0]         w_c;

    assign o_ready  = (state_q == S_IDLE) & ~i_rst;
    assign w_accept = i_valid & o_ready;

`ifdef NSA_SUB_EN
    // Subtract is A + ~B + 1; the forced carry replaces i_ci
    assign w_b_in  = i_sub ? ~i_b : i_b;
    assign w_ci_in = i_sub | i_ci;
`else
    assign w_b_in  = i_b;
    assign w_ci_in = i_ci;
`endif

    // 4-bit carry-lookahead slice on the current nibble
    assign w_na = a_q[{idx_q, 2'b00} +: 4];
    assign w_nb = b_q[{idx_q, 2'b00} +: 4];
    assign w_g  = w_na & w_nb;
    assign w_p  = w_na ^ w_nb;
    assign w_c[0] = cy_q;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_sum = w_p ^ w_c[3:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cy_d    = cy_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    a_d     = i_a;
                    b_d     = w_b_in;
                    cy_d    = w_ci_in;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d[{idx_q, 2'b00} +: 4] = w_sum;
                cy_d = w_c[4];
                if (idx_q == C_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
        end
    end

    assign o_valid = (state_q == S_DONE);
    assign o_s     = res_q;
    assign o_co    = cy_q;
    assign o_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (res_q[WIDTH-1] != a_q[WIDTH-1]);
    assign o_zero  = ~|res_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder
// Purpose  : Directed self-checking bench for nibble_serial_adder (WIDTH=16
//            and WIDTH=8 instances); subtract vectors when NSA_SUB_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ready, i_ci, i_sub;
    logic [15:0] i_a, i_b;
    logic        o_ready, o_valid, o_co, o_ovf, o_zero;
    logic [15:0] o_s;

    logic        v8, ci8, sub8;
    logic [7:0]  a8, b8;
    logic        rdy8, ov8, co8, ovf8, z8;
    logic [7:0]  s8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) u_dut16 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_ci    (i_ci),
`ifdef NSA_SUB_EN
        .i_sub   (i_sub),
`endif
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_s     (o_s),
        .o_co    (o_co),
        .o_ovf   (o_ovf),
        .o_zero  (o_zero)
    );

    nibble_serial_adder #(.WIDTH(8)) u_dut8 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (v8),
        .o_ready (rdy8),
        .i_a     (a8),
        .i_b     (b8),
        .i_ci    (ci8),
`ifdef NSA_SUB_EN
        .i_sub   (sub8),
`endif
        .o_valid (ov8),
        .i_ready (1'b1),
        .o_s     (s8),
        .o_co    (co8),
        .o_ovf   (ovf8),
        .o_zero  (z8)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one operation, wait for o_valid (bounded), check latency and results
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sub, input logic rdy,
                          input logic [15:0] es, input logic eco, input logic eovf,
                          input logic ezero);
        int cyc;
        i_a = a; i_b = b; i_ci = ci; i_sub = sub; i_ready = rdy; i_valid = 1'b1;
        check_eq({tag, " ready"}, {31'd0, o_ready}, 32'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        cyc = 0;
        while (!o_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, " latency"}, cyc, 32'd4);
        check_eq({tag, " s"},    {16'd0, o_s},     {16'd0, es});
        check_eq({tag, " co"},   {31'd0, o_co},    {31'd0, eco});
        check_eq({tag, " ovf"},  {31'd0, o_ovf},   {31'd0, eovf});
        check_eq({tag, " zero"}, {31'd0, o_zero},  {31'd0, ezero});
        if (rdy) begin
            @(posedge clk); #1;
            check_eq({tag, " valid drop"}, {31'd0, o_valid}, 32'd0);
            check_eq({tag, " ready back"}, {31'd0, o_ready}, 32'd1);
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_ci = 1'b0; i_sub = 1'b0;
        i_a = '0; i_b = '0;
        v8 = 1'b0; ci8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst ready low", {31'd0, o_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rst valid", {31'd0, o_valid}, 32'd0);
        check_eq("rst s",     {16'd0, o_s},     32'd0);
        check_eq("rst zero",  {31'd0, o_zero},  32'd1);
        check_eq("rst co",    {31'd0, o_co},    32'd0);

        run_op("add1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
        run_op("addFFFF", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("add7FFF", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);

        // Backpressure: hold result in DONE while inputs wiggle
        run_op("bp", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            i_valid = i[0];
            i_a = 16'(i) * 16'h1111;
            @(posedge clk); #1;
            check_eq("bp valid", {31'd0, o_valid}, 32'd1);
            check_eq("bp s",     {16'd0, o_s},     32'h5555);
            check_eq("bp ready", {31'd0, o_ready}, 32'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp release valid", {31'd0, o_valid}, 32'd0);
        check_eq("bp release ready", {31'd0, o_ready}, 32'd1);

        // Reset while nibble index is 2
        i_a = 16'hABCD; i_b = 16'h1111; i_ci = 1'b0; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("midrst ready low", {31'd0, o_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("midrst valid", {31'd0, o_valid}, 32'd0);
        check_eq("midrst s",     {16'd0, o_s},     32'd0);
        check_eq("midrst co",    {31'd0, o_co},    32'd0);
        check_eq("midrst ovf",   {31'd0, o_ovf},   32'd0);
        check_eq("midrst zero",  {31'd0, o_zero},  32'd1);
        check_eq("midrst ready", {31'd0, o_ready}, 32'd1);
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (o_valid) cyc++;
        end
        check_eq("midrst no valid", cyc, 32'd0);
        run_op("after rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);

`ifdef NSA_SUB_EN
        run_op("sub5m7", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub8000", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif

        // WIDTH=8 instance: two-cycle latency
        a8 = 8'hF0; b8 = 8'h10; v8 = 1'b1;
        check_eq("w8 ready", {31'd0, rdy8}, 32'd1);
        @(posedge clk); #1;
        v8 = 1'b0;
        cyc = 0;
        while (!ov8 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("w8 latency", cyc, 32'd2);
        check_eq("w8 s",    {24'd0, s8},  32'd0);
        check_eq("w8 co",   {31'd0, co8}, 32'd1);
        check_eq("w8 zero", {31'd0, z8},  32'd1);
        check_eq("w8 ovf",  {31'd0, ovf8}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder for the basic CPU datapath.
- Feeds one combinational 4-bit carry-lookahead add slice one nibble per cycle, LSB nibble first, and consumes the slice's sum/carry each cycle.
- Nibble carry is registered between cycles.
- Sits between the operand/register-read stage and the ALU result mux; valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, number of nibbles (localparam, not overridable).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  operands valid.
- o_ready  out  1  block can accept operands.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_ci  in  1  carry-in.
- i_sub  in  1  subtract select; exists only with NSA_SUB_EN.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_s  out  WIDTH  sum.
- o_co  out  1  carry-out of the MSB nibble.
- o_ovf  out  1  two's-complement signed overflow.
- o_zero  out  1  o_s == 0.

Behaviour:
- One clock (i_clk). Reset is synchronous and active-high (i_rst); all state updates on the rising edge of i_clk.
- State machine:
  - IDLE -> RUN on i_valid & o_ready.
  - RUN -> RUN while nibble index < NIB-1; index increments each cycle.
  - RUN -> DONE when index == NIB-1.
  - DONE -> IDLE on i_ready.
- o_ready = (state == IDLE) & ~i_rst. It is combinational, with no dependence on i_valid.
- Accept edge:
  - Latch i_a and i_b (after optional inversion) into operand registers.
  - Latch the carry register from i_ci.
  - Set nibble index to 0.
  - Clear the result register.
- Each RUN cycle, index k:
  - The slice adds A[4k+3:4k], B[4k+3:4k] and the carry register.
  - On the edge, the slice sum is written to result[4k+3:4k] and the slice carry-out to the carry register.
- Latency: if accepted at edge E0, o_valid rises after edge E_NIB (NIB cycles later). For WIDTH=16 this is 4 cycles.
- DONE:
  - o_valid = 1.
  - o_s, o_co, o_ovf and o_zero are stable and held until the edge where i_ready = 1.
  - State returns to IDLE on that edge. o_ready rises the cycle after; no same-cycle re-accept.
- o_co = final carry register.
- o_ovf = (A[W-1] == B[W-1]) & (result[W-1] != A[W-1]), using the latched (possibly inverted) B.
- o_zero = ~|result.
- Outside DONE:
  - o_valid = 0.
  - o_s, o_co, o_ovf, o_zero show register contents; the consumer must ignore them.
- i_valid while not in IDLE is ignored; operands are not re-sampled.
- i_ready outside DONE has no effect.
- Reset values (applied on any edge with i_rst = 1, including mid-RUN or in DONE):
  - State IDLE, index 0.
  - Operand, result and carry registers 0.
  - o_valid 0, o_s 0, o_co 0, o_ovf 0, o_zero 1.
  - o_ready 0 while i_rst is high, 1 on the first cycle after release.
- An in-flight operation is discarded on reset; no partial result is ever flagged valid.
- Arithmetic is modulo 2^WIDTH; the carry-out is reported, never wraps into o_s.

Optional Feature:
- NSA_SUB_EN.
- Defined:
  - Port i_sub exists.
  - On accept with i_sub = 1, B is latched as ~i_b and the carry register as 1; i_ci is ignored.
  - o_co = 1 means no borrow.
  - With i_sub = 0, behaviour is identical to the undefined case.
- Undefined:
  - No i_sub port.
  - B is latched unmodified; the carry register is loaded from i_ci.

Test Plan:
- WIDTH=16: A=0x1234, B=0x4321, ci=0, i_ready=1 -> o_valid exactly 4 cycles after accept; o_s=0x5555, co=0, ovf=0, zero=0; o_ready high the following cycle.
- A=0xFFFF, B=0x0001, ci=0 -> o_s=0x0000, co=1, zero=1, ovf=0. Then A=0x7FFF, B=0x0000, ci=1 -> o_s=0x8000, co=0, ovf=1.
- Backpressure: hold i_ready=0 for 6 cycles in DONE, toggling i_valid and i_a -> o_valid and o_s=0x5555 stable, o_ready=0 throughout; release -> IDLE next edge.
- Reset mid-RUN: assert i_rst one cycle at nibble index 2 -> o_valid never rises; all outputs at reset values; o_ready=1 the cycle after release; new op 0x0001+0x0001 -> 0x0002.
- NSA_SUB_EN: A=0x0005, B=0x0007, sub=1 -> o_s=0xFFFE, co=0. A=0x8000, B=0x0001, sub=1 -> o_s=0x7FFF, co=1, ovf=1.
- WIDTH=8: A=0xF0, B=0x10 -> o_valid 2 cycles after accept, o_s=0x00, co=1, zero=1.
